// File: rtl/gestor_necesidades.sv
// Need levels (hambre/energia/felicidad) with per-need decay, user actions and VIVO/DURMIENDO/MUERTO life state.
// Optional macro NECESIDADES_ACCEL_EN adds input acelerar: every clk counts as a tick while it is high.
module gestor_necesidades #(
    parameter int MAX_LEVEL     = 15,
    parameter int PER_HAMBRE    = 15,
    parameter int PER_ENERGIA   = 20,
    parameter int PER_FELICIDAD = 10,
    parameter int BOOST         = 5,
    parameter int ALERT_TH      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       alimentar,
    input  logic       jugar,
    input  logic       dormir,
`ifdef NECESIDADES_ACCEL_EN
    input  logic       acelerar,
`endif
    output logic [3:0] hambre,
    output logic [3:0] energia,
    output logic [3:0] felicidad,
    output logic [1:0] estado,
    output logic       alerta
);

    typedef enum logic [1:0] {
        ST_VIVO      = 2'b00,
        ST_DURMIENDO = 2'b01,
        ST_MUERTO    = 2'b10
    } estado_t;

    localparam logic [3:0] LP_MAX     = 4'(MAX_LEVEL);
    localparam logic [3:0] LP_TH      = 4'(ALERT_TH);
    localparam logic [4:0] LP_BOOST   = 5'(BOOST);
    localparam logic [5:0] LP_WRAP_H  = 6'(PER_HAMBRE - 1);
    localparam logic [5:0] LP_WRAP_E  = 6'(PER_ENERGIA - 1);
    localparam logic [5:0] LP_WRAP_F  = 6'(PER_FELICIDAD - 1);

    estado_t    r_estado;
    logic [3:0] r_hambre, r_energia, r_felicidad;
    logic [5:0] r_cnt_h, r_cnt_e, r_cnt_f;

    logic       w_tick;
    logic [3:0] w_h_dec, w_e_dec, w_f_dec;
    logic [5:0] w_cnt_h, w_cnt_e, w_cnt_f;

    function automatic logic [3:0] f_dec_sat(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    // 5-bit sum so the carry is visible before clamping to MAX_LEVEL
    function automatic logic [3:0] f_add_sat(input logic [3:0] v, input logic [4:0] inc);
        logic [4:0] s;
        s = {1'b0, v} + inc;
        return (s > {1'b0, LP_MAX}) ? LP_MAX : s[3:0];
    endfunction

`ifdef NECESIDADES_ACCEL_EN
    assign w_tick = tick_1s | acelerar;
`else
    assign w_tick = tick_1s;
`endif

    // Post-decay values; actions are applied on top of these
    always_comb begin
        w_h_dec = r_hambre;
        w_e_dec = r_energia;
        w_f_dec = r_felicidad;
        w_cnt_h = r_cnt_h;
        w_cnt_e = r_cnt_e;
        w_cnt_f = r_cnt_f;
        if (w_tick) begin
            if (r_cnt_h == LP_WRAP_H) begin
                w_cnt_h = 6'd0;
                w_h_dec = f_dec_sat(r_hambre);
            end else begin
                w_cnt_h = r_cnt_h + 6'd1;
            end
            if (r_cnt_f == LP_WRAP_F) begin
                w_cnt_f = 6'd0;
                w_f_dec = f_dec_sat(r_felicidad);
            end else begin
                w_cnt_f = r_cnt_f + 6'd1;
            end
        end
        if (r_estado == ST_DURMIENDO) begin
            w_cnt_e = 6'd0;
            if (w_tick) w_e_dec = f_add_sat(r_energia, 5'd1);
        end else if (w_tick) begin
            if (r_cnt_e == LP_WRAP_E) begin
                w_cnt_e = 6'd0;
                w_e_dec = f_dec_sat(r_energia);
            end else begin
                w_cnt_e = r_cnt_e + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado    <= ST_VIVO;
            r_hambre    <= LP_MAX;
            r_energia   <= LP_MAX;
            r_felicidad <= LP_MAX;
            r_cnt_h     <= 6'd0;
            r_cnt_e     <= 6'd0;
            r_cnt_f     <= 6'd0;
        end else if (r_estado != ST_MUERTO) begin
            if (r_hambre == 4'd0) begin
                r_estado <= ST_MUERTO;
            end else begin
                r_hambre    <= w_h_dec;
                r_energia   <= w_e_dec;
                r_felicidad <= w_f_dec;
                r_cnt_h     <= w_cnt_h;
                r_cnt_e     <= w_cnt_e;
                r_cnt_f     <= w_cnt_f;
                if (r_estado == ST_VIVO) begin
                    if (alimentar) begin
                        r_hambre <= f_add_sat(w_h_dec, LP_BOOST);
                        r_cnt_h  <= 6'd0;
                    end else if (jugar) begin
                        r_felicidad <= f_add_sat(w_f_dec, LP_BOOST);
                        r_cnt_f     <= 6'd0;
                        r_energia   <= f_dec_sat(w_e_dec);
                    end else if (dormir) begin
                        r_estado <= ST_DURMIENDO;
                    end
                end else if (dormir || (w_tick && (w_e_dec == LP_MAX))) begin
                    r_estado <= ST_VIVO;
                end
            end
        end
    end

    assign hambre    = r_hambre;
    assign energia   = r_energia;
    assign felicidad = r_felicidad;
    assign estado    = r_estado;
    assign alerta    = (r_estado != ST_MUERTO) &&
                       ((r_hambre <= LP_TH) || (r_energia <= LP_TH) || (r_felicidad <= LP_TH));

endmodule

// File: tb/tb_gestor_necesidades.sv
// Directed bench for gestor_necesidades: decay timing, actions, sleep, death and reset.
module tb_gestor_necesidades;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1s, alimentar, jugar, dormir;
`ifdef NECESIDADES_ACCEL_EN
    logic       acelerar;
`endif
    logic [3:0] hambre, energia, felicidad;
    logic [1:0] estado;
    logic       alerta;

    int n_cmp = 0;
    int n_bad = 0;

    gestor_necesidades dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1s   (tick_1s),
        .alimentar (alimentar),
        .jugar     (jugar),
        .dormir    (dormir),
`ifdef NECESIDADES_ACCEL_EN
        .acelerar  (acelerar),
`endif
        .hambre    (hambre),
        .energia   (energia),
        .felicidad (felicidad),
        .estado    (estado),
        .alerta    (alerta)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] h, input logic [3:0] e,
                             input logic [3:0] f, input logic [1:0] s, input logic a);
        check({tag, ".hambre"},    {4'd0, hambre},    {4'd0, h});
        check({tag, ".energia"},   {4'd0, energia},   {4'd0, e});
        check({tag, ".felicidad"}, {4'd0, felicidad}, {4'd0, f});
        check({tag, ".estado"},    {6'd0, estado},    {6'd0, s});
        check({tag, ".alerta"},    {7'd0, alerta},    {7'd0, a});
    endtask

    task automatic ticks(input int n);
        tick_1s = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick_1s = 1'b0;
    endtask

    task automatic pulse(input logic t, input logic a, input logic j, input logic d);
        tick_1s = t; alimentar = a; jugar = j; dormir = d;
        @(posedge clk);
        #1;
        tick_1s = 1'b0; alimentar = 1'b0; jugar = 1'b0; dormir = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1 check("async_reset.hambre", {4'd0, hambre}, 8'd15);
        idle(1);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        tick_1s = 1'b0; alimentar = 1'b0; jugar = 1'b0; dormir = 1'b0;
`ifdef NECESIDADES_ACCEL_EN
        acelerar = 1'b0;
`endif
        idle(2);
        check_all("reset", 4'd15, 4'd15, 4'd15, 2'b00, 1'b0);
        reset = 1'b1;
        idle(1);

        // 1: first decrements on the PER-th tick
        ticks(9);
        check("t9.felicidad", {4'd0, felicidad}, 8'd15);
        ticks(1);
        check("t10.felicidad", {4'd0, felicidad}, 8'd14);
        ticks(4);
        check("t14.hambre", {4'd0, hambre}, 8'd15);
        ticks(1);
        check("t15.hambre", {4'd0, hambre}, 8'd14);
        ticks(4);
        check("t19.energia", {4'd0, energia}, 8'd15);
        ticks(1);
        check_all("t20", 4'd14, 4'd14, 4'd13, 2'b00, 1'b0);

        // 2: feeding restores hunger and restarts its period
        ticks(55);
        check_all("t75", 4'd10, 4'd12, 4'd8, 2'b00, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("feed.hambre", {4'd0, hambre}, 8'd15);
        ticks(14);
        check("feed+14.hambre", {4'd0, hambre}, 8'd15);
        ticks(1);
        check_all("t90", 4'd14, 4'd11, 4'd6, 2'b00, 1'b0);
        ticks(44);
        check("t134.hambre", {4'd0, hambre}, 8'd12);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("t135_feed_on_tick", 4'd15, 4'd9, 4'd2, 2'b00, 1'b1);
        ticks(14);
        check("t149.hambre", {4'd0, hambre}, 8'd15);
        ticks(1);
        check("t150.hambre", {4'd0, hambre}, 8'd14);

        // 3: sleep, energy recovery and wake on full energy
        do_reset();
        ticks(60);
        check_all("s60", 4'd11, 4'd12, 4'd9, 2'b00, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("sleep.estado", {6'd0, estado}, 8'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("sleep_jugar_ignored", 4'd11, 4'd12, 4'd9, 2'b01, 1'b0);
        ticks(1);
        check_all("sleep_t1", 4'd11, 4'd13, 4'd9, 2'b01, 1'b0);
        ticks(1);
        check("sleep_t2.energia", {4'd0, energia}, 8'd14);
        ticks(1);
        check_all("sleep_wake", 4'd11, 4'd15, 4'd9, 2'b00, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("toggle_in.estado", {6'd0, estado}, 8'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("toggle_out.estado", {6'd0, estado}, 8'd0);

        // 4: simultaneous actions, only feeding wins
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        check_all("all_actions", 4'd15, 4'd15, 4'd9, 2'b00, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("jugar", 4'd15, 4'd14, 4'd14, 2'b00, 1'b0);

        // 5: starvation and freeze in MUERTO
        do_reset();
        ticks(120);
        check_all("d120", 4'd7, 4'd9, 4'd3, 2'b00, 1'b1);
        ticks(105);
        check_all("d225", 4'd0, 4'd4, 4'd0, 2'b00, 1'b1);
        idle(1);
        check_all("dead", 4'd0, 4'd4, 4'd0, 2'b10, 1'b0);
        ticks(20);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check_all("dead_frozen", 4'd0, 4'd4, 4'd0, 2'b10, 1'b0);
        do_reset();
        check_all("revive", 4'd15, 4'd15, 4'd15, 2'b00, 1'b0);

        // 6: acceleration input, or plain idle clocks without it
`ifdef NECESIDADES_ACCEL_EN
        acelerar = 1'b1;
        idle(15);
        acelerar = 1'b0;
        check("accel.hambre", {4'd0, hambre}, 8'd14);
`else
        idle(15);
        check("noaccel.hambre", {4'd0, hambre}, 8'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
